charge_pump_ctrl: RTL and testbench
===================================

# charge_pump_ctrl

Digital sequencer for the on-chip analog charge pump. It generates the non-overlapping two-phase pump clocks `phi1`/`phi2` from the system clock, with programmable phase width and dead time. It ramps pump activity through a soft-start and regulates the output by skipping pump slots while the analog comparator reports the output above target. It sits in the digital domain between the user configuration pins and the analog pump switches.

## Interface
Parameters:
- `DIV_W`, 8: width of the phase-width setting.
- `DEAD_W`, 3: width of the dead-time setting.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: pump enable, synchronous to `clk`.
- `div` in `DIV_W`: each phase lasts `div+1` clk cycles.
- `dead` in `DEAD_W`: dead-time cycles. Effective value `deff = max(dead,1)`.
- `cmp_in` in 1: asynchronous comparator output. 1 means the pump output is above target.
- `phi1` out 1: pump phase 1, registered.
- `phi2` out 1: pump phase 2, registered.
- `busy` out 1: state is not IDLE.
- `ss_done` out 1: soft-start complete.
- `skip_cnt` out 8: saturating count of comparator-skipped slots.

## Operation
- `cmp_in` passes through a 2-flop synchronizer to give `cmp_s`. Only `cmp_s` is used.
- States:
  - IDLE: both phases low.
  - PH1: `phi1=1`.
  - D1: dead time, both low.
  - PH2: `phi2=1`.
  - D2: dead time, both low.
  - SKIP: both low.
- A slot is PH1→D1→PH2→D2, or SKIP for the same total length. Slot length `L = 2*(div+1) + 2*deff`.
- `div` and `deff` are latched at each slot start and held constant for that slot.
- Slot start happens on IDLE with `en=1`, or at the end of D2/SKIP with `en=1`. At slot start:
  - `slot_idx` (4 bits) is the index of the new slot.
  - Pump (go to PH1) iff `slot_idx <= ss_lvl` and `cmp_s==0`.
  - Otherwise go to SKIP.
  - If the slot skips with `slot_idx <= ss_lvl` and `cmp_s==1`, `skip_cnt` increments, saturating at 255.
- `slot_idx` increments (wrapping) after every slot, whether pumped or skipped.
- Soft-start:
  - `ss_lvl` (4 bits) is 0 after enable.
  - `ss_lvl` increments each time `slot_idx` wraps 15→0.
  - `ss_lvl` saturates at 15. `ss_done = (ss_lvl==15)`.
  - Result: at level n, n+1 of every 16 slots may pump.
- Disable:
  - `en=0` during PH1 or PH2: the phase ends at the next edge, then the matching dead state runs for `deff` cycles, then IDLE.
  - `en=0` during D1: D1 completes, then IDLE. PH2 is not entered.
  - `en=0` during D2 or SKIP: that state completes, then IDLE.
  - `phi1` and `phi2` are never both high. Each phase high is always followed by at least `deff` low cycles.
- Entering IDLE clears `ss_lvl` and `slot_idx`. `skip_cnt` clears on IDLE→slot-start (en rising).
- Reset values: state IDLE; `phi1=phi2=busy=ss_done=0`; `skip_cnt=0`; `ss_lvl=slot_idx=0`; synchronizer flops 0.

## Timing
- Latency from `en` to `phi1`: `en` sampled 1 in IDLE at edge k gives `phi1=1` from edge k, registered, visible in cycle k+1. It stays high for exactly `div+1` cycles.
- Phase sequence: `phi1` high `div+1` cycles → low `deff` cycles → `phi2` high `div+1` cycles → low `deff` cycles. The next slot starts with no gap.
- Comparator latency: `cmp_in` change to effect is 2 clk (synchronizer) plus the wait to the next slot start. A slot in progress is never truncated by `cmp_s`.
- `busy` rises with the slot-start edge. It falls on the edge that enters IDLE.
- `rst` mid-slot forces `phi1=phi2=0` immediately (asynchronous). This is the only path that may cut a dead time short.
- `div` or `dead` changes mid-slot take effect at the next slot start only.

## Test plan
- Reset, then `en=1`, `cmp_in=0`, `div=1`, `dead=2`:
  - slot 0 gives `phi1` 2 cycles high, 2 low, `phi2` 2 high, 2 low (period 8).
  - slots 1–15 are SKIP with both phases low for 8 cycles each.
  - `skip_cnt` stays 0.
- Soft-start ramp, same config: 16 slots at each level.
  - Pumped slots per 16-slot window are 1, 2, …, 16.
  - `ss_done` rises at the start of slot 240. After that, every slot pumps.
- After `ss_done`, hold `cmp_in=1` for 5 slots, with `div=0`, `dead=0`:
  - each slot is SKIP of length 4 (`deff=1`).
  - `skip_cnt` increments by 1 per skipped slot.
  - pumping resumes within one slot after `cmp_in=0` plus 2 cycles.
- `en=0` in the middle of PH1 (`div=7`):
  - `phi1` falls on the next edge.
  - both phases stay low for `deff` cycles, then `busy=0`.
  - `phi2` never pulses.
  - re-enable restarts at `ss_lvl=0`.
- Change `div` from 3 to 0 during PH2: the current slot keeps 4-cycle phases; the next slot uses 1-cycle phases.
- Assert `rst` during PH2: `phi2=0` without waiting for a clock edge; all counters read 0 after release.
- All tests: an assertion checks every cycle that `phi1 & phi2` is never 1.

Source files
------------

// File: rtl/charge_pump_ctrl.sv
// charge_pump_ctrl
//   Sequencer for the on-chip charge pump. Produces non-overlapping two-phase
//   pump clocks with programmable phase width and dead time, ramps activity
//   through a 16-level soft-start, and skips pump slots while the synchronised
//   comparator reports the output above target.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   en        pump enable (synchronous)
//   div       phase width, each phase lasts div+1 cycles
//   dead      dead time cycles, 0 treated as 1
//   cmp_in    asynchronous comparator, 1 = output above target
//   phi1/phi2 registered pump phases, never high together
//   busy      sequencer not idle
//   ss_done   soft-start reached full level
//   skip_cnt  saturating count of comparator-skipped slots
module charge_pump_ctrl #(
   parameter int unsigned DIV_W  = 8,
   parameter int unsigned DEAD_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  div,
   input  logic [DEAD_W-1:0] dead,
   input  logic              cmp_in,
   output logic              phi1,
   output logic              phi2,
   output logic              busy,
   output logic              ss_done,
   output logic [7:0]        skip_cnt
);

   // Wide enough for the longest skip slot: 2*(div+1) + 2*deff - 1.
   localparam int unsigned CNT_W = ((DIV_W > DEAD_W) ? DIV_W : DEAD_W) + 2;

   typedef enum logic [2:0] {IDLE, PH1, D1, PH2, D2, SKIP} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [DIV_W-1:0]   div_l, div_n;
   logic [DEAD_W-1:0]  deff_l, deff_n;
   logic [3:0]         slot_idx, idx_n;
   logic [3:0]         ss_lvl, lvl_n;
   logic [7:0]         skip_n;
   logic               stop, stop_n;
   logic               cmp_q, cmp_s;
   logic               phase_end, dead_end, skip_end;
   logic               go_start, go_idle;
   logic [3:0]         cand_idx, cand_lvl;
   logic               eligible;
   logic [7:0]         skip_base;

   assign phase_end = (cnt == CNT_W'(div_l));
   assign dead_end  = (cnt == CNT_W'(deff_l) - CNT_W'(1));
   assign skip_end  = (cnt == (CNT_W'(div_l) << 1) + (CNT_W'(deff_l) << 1) + CNT_W'(1));

   // Index/level of the slot that would start now. The soft-start level
   // steps up when the previous slot was the last one (15) of its window.
   assign cand_idx  = (state == IDLE) ? 4'h0 : slot_idx + 4'h1;
   assign cand_lvl  = (state == IDLE) ? 4'h0 :
                      ((slot_idx == 4'hF) && (ss_lvl != 4'hF)) ? ss_lvl + 4'h1 : ss_lvl;
   assign eligible  = (cand_idx <= cand_lvl);
   assign skip_base = (state == IDLE) ? 8'h00 : skip_cnt;

   assign busy    = (state != IDLE);
   assign ss_done = (ss_lvl == 4'hF);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt + CNT_W'(1);
      div_n    = div_l;
      deff_n   = deff_l;
      idx_n    = slot_idx;
      lvl_n    = ss_lvl;
      skip_n   = skip_cnt;
      // A disable seen anywhere in a slot is remembered so the slot winds
      // down through its dead time even if en returns meanwhile.
      stop_n   = stop | ((state != IDLE) & ~en);
      go_start = 1'b0;
      go_idle  = 1'b0;

      case (state)
         IDLE: begin
            cnt_n    = '0;
            go_start = en;
         end
         PH1: begin
            if (!en || phase_end) begin
               state_n = D1;
               cnt_n   = '0;
            end
         end
         D1: begin
            if (dead_end) begin
               if (stop_n) begin
                  go_idle = 1'b1;
               end else begin
                  state_n = PH2;
                  cnt_n   = '0;
               end
            end
         end
         PH2: begin
            if (!en || phase_end) begin
               state_n = D2;
               cnt_n   = '0;
            end
         end
         D2: begin
            if (dead_end) begin
               go_idle  = stop_n;
               go_start = ~stop_n;
            end
         end
         SKIP: begin
            if (skip_end) begin
               go_idle  = stop_n;
               go_start = ~stop_n;
            end
         end
         default: go_idle = 1'b1;
      endcase

      if (go_start) begin
         state_n = (eligible && !cmp_s) ? PH1 : SKIP;
         cnt_n   = '0;
         div_n   = div;
         deff_n  = (dead == '0) ? DEAD_W'(1) : dead;
         idx_n   = cand_idx;
         lvl_n   = cand_lvl;
         stop_n  = 1'b0;
         skip_n  = (eligible && cmp_s && (skip_base != 8'hFF)) ? skip_base + 8'h01 : skip_base;
      end

      if (go_idle) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
         lvl_n   = '0;
         stop_n  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         div_l    <= '0;
         deff_l   <= DEAD_W'(1);
         slot_idx <= '0;
         ss_lvl   <= '0;
         skip_cnt <= '0;
         stop     <= 1'b0;
         cmp_q    <= 1'b0;
         cmp_s    <= 1'b0;
         phi1     <= 1'b0;
         phi2     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_l    <= div_n;
         deff_l   <= deff_n;
         slot_idx <= idx_n;
         ss_lvl   <= lvl_n;
         skip_cnt <= skip_n;
         stop     <= stop_n;
         cmp_q    <= cmp_in;
         cmp_s    <= cmp_q;
         phi1     <= (state_n == PH1);
         phi2     <= (state_n == PH2);
      end
   end

endmodule

// File: tb/tb_charge_pump_ctrl.sv
// tb_charge_pump_ctrl
//   Scoreboard bench for charge_pump_ctrl. A slot-level timeline model turns
//   the inputs seen at each rising edge into the expected outputs for the
//   following cycle and queues them; a monitor on the falling edge pops and
//   compares.
module tb_charge_pump_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       cmp_in = 1'b0;
   logic [7:0] div = 8'd0;
   logic [2:0] dead = 3'd0;
   logic       phi1, phi2, busy, ss_done;
   logic [7:0] skip_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [11:0] exp_q[$];

   localparam int T_P1 = 1, T_D1 = 2, T_P2 = 3, T_D2 = 4, T_SK = 5;

   int m_busy = 0, m_stop = 0, m_n = 0, m_skip = 0, m_deff = 1, m_last = 0;
   int m_plan[$];
   bit c1 = 1'b0, c2 = 1'b0;

   charge_pump_ctrl #(.DIV_W(8), .DEAD_W(3)) dut (
      .clk(clk), .rst(rst), .en(en), .div(div), .dead(dead), .cmp_in(cmp_in),
      .phi1(phi1), .phi2(phi2), .busy(busy), .ss_done(ss_done), .skip_cnt(skip_cnt)
   );

   always #5 clk = ~clk;

   // Build the whole cycle timeline of a new slot from its number since enable.
   task automatic start_slot(input bit cs);
      int  idx, lvl;
      bit  elig;
      idx = m_n % 16;
      lvl = (m_n / 16 > 15) ? 15 : m_n / 16;
      elig = (idx <= lvl);
      m_deff = (dead == 3'd0) ? 1 : int'(dead);
      if (elig && cs && m_skip < 255) m_skip++;
      m_plan.delete();
      if (elig && !cs) begin
         repeat (int'(div) + 1) m_plan.push_back(T_P1);
         repeat (m_deff)        m_plan.push_back(T_D1);
         repeat (int'(div) + 1) m_plan.push_back(T_P2);
         repeat (m_deff)        m_plan.push_back(T_D2);
      end else begin
         repeat (2 * (int'(div) + 1) + 2 * m_deff) m_plan.push_back(T_SK);
      end
      m_stop = 0;
      m_busy = 1;
      m_last = m_plan.pop_front();
   endtask

   task automatic model_step();
      bit cs;
      int keep[$];
      int lvl;
      logic [11:0] e;
      if (rst) begin
         m_busy = 0; m_stop = 0; m_n = 0; m_skip = 0; m_last = 0;
         m_plan.delete();
         c1 = 1'b0; c2 = 1'b0;
      end else begin
         cs = c2; c2 = c1; c1 = cmp_in;
         if (m_busy != 0) begin
            if (!en) begin
               m_stop = 1;
               if (m_last == T_P1 || m_last == T_P2) begin
                  m_plan.delete();
                  repeat (m_deff) m_plan.push_back(m_last + 1);
               end else begin
                  keep.delete();
                  while (m_plan.size() > 0 && m_plan[0] == m_last) keep.push_back(m_plan.pop_front());
                  m_plan = keep;
               end
            end
            if (m_plan.size() == 0) begin
               if (m_stop != 0) begin
                  m_busy = 0; m_stop = 0; m_n = 0; m_last = 0;
               end else begin
                  m_n++;
                  start_slot(cs);
               end
            end else begin
               m_last = m_plan.pop_front();
            end
         end else if (en) begin
            m_n = 0;
            m_skip = 0;
            start_slot(cs);
         end
      end
      lvl = (m_n / 16 > 15) ? 15 : m_n / 16;
      e = {(m_last == T_P1), (m_last == T_P2), (m_busy != 0), ((m_busy != 0) && (lvl == 15)), 8'(m_skip)};
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_high(input bit which, input int budget);
      int k;
      k = 0;
      while (((which ? phi2 : phi1) !== 1'b1) && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (k >= budget) begin
         errors++;
         $display("FAIL wait_phi%0d: phase never went high within %0d cycles (cycle %0d)", which ? 2 : 1, budget, cyc);
      end
   endtask

   // Monitor: compares every queued expectation and checks phase overlap.
   initial begin
      logic [11:0] ex, act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            ex  = exp_q.pop_front();
            act = {phi1, phi2, busy, ss_done, skip_cnt};
            checks++;
            if (act !== ex) begin
               errors++;
               if (errors <= 30)
                  $display("FAIL outputs cycle %0d: got phi1=%b phi2=%b busy=%b ss_done=%b skip=%0d, want phi1=%b phi2=%b busy=%b ss_done=%b skip=%0d",
                           cyc, act[11], act[10], act[9], act[8], act[7:0], ex[11], ex[10], ex[9], ex[8], ex[7:0]);
            end
            checks++;
            assert (!(phi1 && phi2)) else begin
               errors++;
               $display("FAIL overlap cycle %0d: phi1=%b phi2=%b, want not both 1", cyc, phi1, phi2);
            end
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Soft-start ramp: div=1, dead=2, comparator low
      div = 8'd1; dead = 3'd2; cmp_in = 1'b0; en = 1'b1;
      repeat (2200) tick();

      // Comparator high at full level with minimum timing, through saturation
      div = 8'd0; dead = 3'd0; cmp_in = 1'b1;
      repeat (1100) tick();
      cmp_in = 1'b0;
      repeat (60) tick();

      // Disable in the middle of a long PH1, then re-enable
      en = 1'b0;
      repeat (20) tick();
      div = 8'd7; dead = 3'd3; en = 1'b1;
      wait_high(1'b0, 20);
      repeat (3) tick();
      en = 1'b0;
      repeat (15) tick();
      en = 1'b1;
      repeat (200) tick();

      // Phase width change during PH2
      en = 1'b0;
      repeat (20) tick();
      div = 8'd3; dead = 3'd1; en = 1'b1;
      wait_high(1'b1, 40);
      tick();
      div = 8'd0;
      repeat (100) tick();

      // Randomised enable, timing and comparator activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) en = ~en;
         if ($urandom_range(0, 19) == 0) div = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 19) == 0) dead = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) cmp_in = ~cmp_in;
         tick();
      end

      // Asynchronous reset during PH2
      en = 1'b0; cmp_in = 1'b0;
      repeat (30) tick();
      div = 8'd4; dead = 3'd2; en = 1'b1;
      wait_high(1'b1, 40);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (phi1 !== 1'b0 || phi2 !== 1'b0 || busy !== 1'b0 || skip_cnt !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got phi1=%b phi2=%b busy=%b skip=%0d, want all 0", phi1, phi2, busy, skip_cnt);
      end
      en = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
